// File: rtl/soc_system_phi_step_pkg.sv
// Shared types and constants for the TDC PLL dynamic phase-step sequencer.
package soc_system_phi_step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_WAIT_LOCK,
    ST_DONE
  } phi_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STEPS  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_POS    = 2'd3;

  localparam int CTRL_START      = 0;
  localparam int CTRL_UPDOWN     = 1;
  localparam int CTRL_ABORT      = 2;
  localparam int CTRL_IRQ_EN     = 3;
  localparam int CTRL_CNTSEL_LSB = 4;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR    = 2;
  localparam int STAT_LOCKED = 3;

endpackage

// File: rtl/soc_system_phi_step_sync2.sv
// Two-flop synchroniser for asynchronous PLL status inputs.
module soc_system_phi_step_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/soc_system_phi_step_ctrl.sv
// Avalon-MM sequencer driving the TDC PLL phasestep/phasedone handshake.
// Optional macro PHI_STEP_IRQ_EN adds an irq output and a readable CTRL.irq_en bit.
//
// state        | meaning
// ST_IDLE      | waiting for a start write
// ST_STEP      | phasestep held high for PULSE_CYCLES
// ST_WAIT_LO   | waiting for phasedone to fall
// ST_WAIT_HI   | waiting for phasedone to rise, then position update
// ST_WAIT_LOCK | waiting for PLL lock before next step
// ST_DONE      | one-cycle completion, sets sticky done
module soc_system_phi_step_ctrl
  import soc_system_phi_step_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNTSEL_W       = 5,
  parameter int POS_W          = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          address,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic                read,
  output logic [31:0]         readdata,
  input  logic                pll_locked,
  input  logic                phasedone,
  output logic                phasestep,
  output logic                phaseupdown,
  output logic [CNTSEL_W-1:0] phasecounterselect
`ifdef PHI_STEP_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  PULSE_LAST = 4'(PULSE_CYCLES - 1);

  phi_state_t        state;
  logic [3:0]        pulse_cnt;
  logic [15:0]       tmo_cnt;
  logic [15:0]       remaining;
  logic [15:0]       steps_r;
  logic [POS_W-1:0]  pos_r;
  logic              done_r;
  logic              err_r;
  logic              locked_sync;
  logic              phasedone_sync;
  logic [31:0]       rd_mux;
  logic              unused_in;

  soc_system_phi_step_sync2 u_sync_locked (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_sync)
  );

  soc_system_phi_step_sync2 u_sync_phasedone (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (phasedone),
    .q       (phasedone_sync)
  );

  logic busy;
  logic wr_ctrl, wr_steps, wr_status, wr_pos;
  logic ctrl_abort, ctrl_start;

  assign busy       = (state != ST_IDLE);
  assign wr_ctrl    = write && (address == ADDR_CTRL);
  assign wr_steps   = write && (address == ADDR_STEPS);
  assign wr_status  = write && (address == ADDR_STATUS);
  assign wr_pos     = write && (address == ADDR_POS);
  assign ctrl_abort = wr_ctrl && writedata[CTRL_ABORT];
  assign ctrl_start = wr_ctrl && writedata[CTRL_START] && !writedata[CTRL_ABORT];
  assign unused_in  = read ^ (^writedata);

`ifdef PHI_STEP_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
    end else if (wr_ctrl && !busy) begin
      irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  assign irq = (done_r | err_r) & irq_en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      pulse_cnt          <= '0;
      tmo_cnt            <= '0;
      remaining          <= '0;
      steps_r            <= '0;
      pos_r              <= '0;
      done_r             <= 1'b0;
      err_r              <= 1'b0;
      phasestep          <= 1'b0;
      phaseupdown        <= 1'b0;
      phasecounterselect <= '0;
    end else begin
      // Timeout counter restarts on every state change; wait states re-arm it below.
      tmo_cnt <= '0;

      if (wr_steps && !busy) steps_r <= writedata[15:0];
      if (wr_pos && !busy)   pos_r   <= '0;
      if (wr_status) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end

      if (ctrl_abort && busy) begin
        state     <= ST_IDLE;
        phasestep <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ctrl_start) begin
              if (steps_r == 16'd0) begin
                done_r <= 1'b1;
              end else begin
                phaseupdown        <= writedata[CTRL_UPDOWN];
                phasecounterselect <= writedata[CTRL_CNTSEL_LSB +: CNTSEL_W];
                remaining          <= steps_r;
                done_r             <= 1'b0;
                err_r              <= 1'b0;
                phasestep          <= 1'b1;
                pulse_cnt          <= PULSE_LAST;
                state              <= ST_STEP;
              end
            end
          end

          ST_STEP: begin
            if (pulse_cnt == 4'd0) begin
              phasestep <= 1'b0;
              state     <= ST_WAIT_LO;
            end else begin
              pulse_cnt <= pulse_cnt - 4'd1;
            end
          end

          ST_WAIT_LO: begin
            if (!phasedone_sync) begin
              state <= ST_WAIT_HI;
            end else if (tmo_cnt == TMO_LAST) begin
              err_r     <= 1'b1;
              phasestep <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          ST_WAIT_HI: begin
            if (phasedone_sync) begin
              pos_r     <= phaseupdown ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
              remaining <= remaining - 16'd1;
              state     <= ST_WAIT_LOCK;
            end else if (tmo_cnt == TMO_LAST) begin
              err_r     <= 1'b1;
              phasestep <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          ST_WAIT_LOCK: begin
            if (locked_sync) begin
              if (remaining != 16'd0) begin
                phasestep <= 1'b1;
                pulse_cnt <= PULSE_LAST;
                state     <= ST_STEP;
              end else begin
                state <= ST_DONE;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              err_r     <= 1'b1;
              phasestep <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end

          ST_DONE: begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end

          default: begin
            phasestep <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL: begin
`ifdef PHI_STEP_IRQ_EN
        rd_mux[CTRL_IRQ_EN] = irq_en;
`endif
      end
      ADDR_STEPS:  rd_mux[15:0] = steps_r;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]   = busy;
        rd_mux[STAT_DONE]   = done_r;
        rd_mux[STAT_ERR]    = err_r;
        rd_mux[STAT_LOCKED] = locked_sync;
      end
      ADDR_POS:    rd_mux = {{(32-POS_W){pos_r[POS_W-1]}}, pos_r};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
